// File: rtl/bn_res_pkg.sv
// Shared types and helpers for the batch-norm / residual pipeline.
// Sum width derivation, rounding shift and saturation to the output width.
package bn_res_pkg;

    localparam int CALC_W = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef struct packed {
        calc_t val;
        logic  sat;
    } sat_res_t;

    function automatic int sum_w(input int iw, input int pw);
        return iw + pw + 2;
    endfunction

    function automatic calc_t sat_max(input int dw);
        return (calc_t'(1) <<< (dw - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t sat_min(input int dw);
        return -(calc_t'(1) <<< (dw - 1));
    endfunction

    localparam calc_t DEF_SAT_MAX = sat_max(16);
    localparam calc_t DEF_SAT_MIN = sat_min(16);

    // Round half up, arithmetic shift, then clamp to a dw-bit signed range.
    function automatic sat_res_t sat_round(
        input calc_t sum,
        input int    shift,
        input int    dw
    );
        calc_t    r;
        sat_res_t o;
        r = sum;
        if (shift > 0) begin
            r = (sum + (calc_t'(1) <<< (shift - 1))) >>> shift;
        end
        o.sat = 1'b0;
        o.val = r;
        if (r > sat_max(dw)) begin
            o.val = sat_max(dw);
            o.sat = 1'b1;
        end else if (r < sat_min(dw)) begin
            o.val = sat_min(dw);
            o.sat = 1'b1;
        end
        return o;
    endfunction

endpackage

// File: rtl/bn_res_lane.sv
// One channel of the BN/residual datapath.
// S1 registers product, bias and gated residual; S2 registers the result.
module bn_res_lane
    import bn_res_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int PARA_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld1,
    input  logic                         ld2,
    input  logic signed [IN_WIDTH-1:0]   data_in,
    input  logic signed [PARA_WIDTH-1:0] bn_a,
    input  logic signed [PARA_WIDTH-1:0] bn_b,
    input  logic signed [DATA_WIDTH-1:0] res,
    input  logic                         res_en,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         sat_flag
);

    localparam int PROD_W = IN_WIDTH + PARA_WIDTH;
    localparam int SUM_W  = sum_w(IN_WIDTH, PARA_WIDTH);

    logic signed [PROD_W-1:0]     prod_d, prod_q;
    logic signed [PARA_WIDTH-1:0] b_q;
    logic signed [DATA_WIDTH-1:0] r_d, r_q;
    logic signed [SUM_W-1:0]      sum;
    sat_res_t                     rnd;
    logic signed [DATA_WIDTH-1:0] out_d, out_q;
    logic                         flag_q;

    // Full-width multiply, residual gating, and the S2 add/round/clamp.
    always_comb begin
        prod_d = PROD_W'(bn_a) * PROD_W'(data_in);
        r_d    = res_en ? res : '0;
        sum    = SUM_W'(prod_q) + SUM_W'(b_q) + SUM_W'(r_q);
        rnd    = sat_round(calc_t'(sum), FRAC_SHIFT, DATA_WIDTH);
        out_d  = DATA_WIDTH'(rnd.val);
    end

    // Stage 1 operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            b_q    <= '0;
            r_q    <= '0;
        end else if (ld1) begin
            prod_q <= prod_d;
            b_q    <= bn_b;
            r_q    <= r_d;
        end
    end

    // Stage 2 result and saturation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            flag_q <= 1'b0;
        end else if (ld2) begin
            out_q  <= out_d;
            flag_q <= rnd.sat;
        end
    end

    assign data_out = out_q;
    assign sat_flag = flag_q;

endmodule

// File: rtl/bn_res_pipe.sv
// Two-stage BN/residual pipeline with valid/ready back-pressure.
// BN_RES_SAT_CNT_EN enables the saturating saturation-event counter.
module bn_res_pipe
    import bn_res_pkg::*;
#(
    parameter int IN_WIDTH    = 8,
    parameter int PARA_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int CHANNEL_NUM = 128,
    parameter int FM_DEPTH    = 64,
    parameter int FRAC_SHIFT  = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              res_en,
    input  logic [CHANNEL_NUM*IN_WIDTH-1:0]   data_in,
    input  logic [FM_DEPTH*DATA_WIDTH-1:0]    res,
    input  logic [CHANNEL_NUM*PARA_WIDTH-1:0] bn_a,
    input  logic [CHANNEL_NUM*PARA_WIDTH-1:0] bn_b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CHANNEL_NUM*DATA_WIDTH-1:0] data_out,
    output logic [CHANNEL_NUM-1:0]            sat_flag,
    output logic [31:0]                       sat_cnt,
    input  logic                              sat_clr
);

    logic v1_q, v2_q;
    logic en1, en2;
    logic ld1, ld2;

    assign en2       = !v2_q || out_ready;
    assign en1       = !v1_q || en2;
    assign in_ready  = en1 && !rst;
    assign ld1       = in_valid && in_ready;
    assign ld2       = en2 && v1_q;
    assign out_valid = v2_q;

    // Valid bits advance whenever their stage is enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (en1) v1_q <= in_valid;
            if (en2) v2_q <= v1_q;
        end
    end

    for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] res_ch;
        if (i < FM_DEPTH) begin : g_res
            assign res_ch = res[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_nores
            assign res_ch = '0;
        end
        bn_res_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .PARA_WIDTH(PARA_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .FRAC_SHIFT(FRAC_SHIFT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .ld1     (ld1),
            .ld2     (ld2),
            .data_in (data_in[i*IN_WIDTH +: IN_WIDTH]),
            .bn_a    (bn_a[i*PARA_WIDTH +: PARA_WIDTH]),
            .bn_b    (bn_b[i*PARA_WIDTH +: PARA_WIDTH]),
            .res     (res_ch),
            .res_en  (res_en),
            .data_out(data_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .sat_flag(sat_flag[i])
        );
    end

`ifdef BN_RES_SAT_CNT_EN
    logic [31:0] cnt_d, cnt_q, pop;
    logic [32:0] acc;

    // Add this beat's flag popcount on handshake; clear has priority.
    always_comb begin
        pop = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            pop = pop + 32'(sat_flag[i]);
        end
        acc   = {1'b0, cnt_q} + {1'b0, pop};
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = acc[32] ? '1 : acc[31:0];
        end
        if (sat_clr) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign sat_cnt = cnt_q;
`else
    logic sat_clr_unused;
    assign sat_clr_unused = sat_clr;
    assign sat_cnt        = '0;
`endif

endmodule

// File: tb/tb_bn_res_pipe.sv
// Self-checking bench for bn_res_pipe.
// Directed steps plus random streams against a behavioural model.
module tb_bn_res_pipe;

    localparam int CH = 128;
    localparam int IW = 8;
    localparam int PW = 16;
    localparam int DW = 16;
    localparam int FM = 64;
    localparam int C2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid, in_ready, res_en;
    logic              out_valid, out_ready, sat_clr;
    logic [CH*IW-1:0]  data_in;
    logic [FM*DW-1:0]  res;
    logic [CH*PW-1:0]  bn_a, bn_b;
    logic [CH*DW-1:0]  data_out;
    logic [CH-1:0]     sat_flag;
    logic [31:0]       sat_cnt;

    logic              d2_in_valid, d2_in_ready, d2_out_valid;
    logic [C2*IW-1:0]  d2_data_in;
    logic [2*DW-1:0]   d2_res;
    logic [C2*PW-1:0]  d2_bn_a, d2_bn_b;
    logic [C2*DW-1:0]  d2_data_out;
    logic [C2-1:0]     d2_sat_flag;
    logic [31:0]       d2_sat_cnt;

    int     n_cmp = 0;
    int     n_err = 0;
    longint exp_cnt = 0;

    bn_res_pipe #(
        .IN_WIDTH(IW), .PARA_WIDTH(PW), .DATA_WIDTH(DW),
        .CHANNEL_NUM(CH), .FM_DEPTH(FM), .FRAC_SHIFT(0)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .res_en(res_en),
        .data_in(data_in), .res(res), .bn_a(bn_a), .bn_b(bn_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .sat_flag(sat_flag),
        .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    bn_res_pipe #(
        .IN_WIDTH(IW), .PARA_WIDTH(PW), .DATA_WIDTH(DW),
        .CHANNEL_NUM(C2), .FM_DEPTH(2), .FRAC_SHIFT(2)
    ) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .res_en(1'b0),
        .data_in(d2_data_in), .res(d2_res), .bn_a(d2_bn_a), .bn_b(d2_bn_b),
        .out_valid(d2_out_valid), .out_ready(1'b1),
        .data_out(d2_data_out), .sat_flag(d2_sat_flag),
        .sat_cnt(d2_sat_cnt), .sat_clr(1'b0)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic longint ref_ch(longint a, longint x, longint b,
                                      longint r, int shift, output bit f);
        longint s;
        s = a * x + b + r;
        if (shift > 0) s = (s + (64'sd1 << (shift - 1))) >>> shift;
        f = 1'b0;
        if (s > 32767) begin
            s = 32767;
            f = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            f = 1'b1;
        end
        return s;
    endfunction

    function automatic longint exp_sat();
`ifdef BN_RES_SAT_CNT_EN
        return exp_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic expect_main(output logic [CH*DW-1:0] ed,
                               output logic [CH-1:0] ef);
        for (int i = 0; i < CH; i++) begin
            longint r, v;
            bit     f;
            r = 0;
            if (res_en && i < FM) r = longint'($signed(res[i*DW +: DW]));
            v = ref_ch(longint'($signed(bn_a[i*PW +: PW])),
                       longint'($signed(data_in[i*IW +: IW])),
                       longint'($signed(bn_b[i*PW +: PW])), r, 0, f);
            ed[i*DW +: DW] = v[DW-1:0];
            ef[i] = f;
        end
    endtask

    task automatic chk_v(string tag, logic [63:0] o, logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, $signed(o), $signed(e));
        end
    endtask

    task automatic chk(string tag,
                       logic [CH*DW-1:0] od, logic [CH*DW-1:0] ed,
                       logic [CH-1:0] of_, logic [CH-1:0] ef);
        int k;
        n_cmp++;
        assert (od === ed && of_ === ef) else begin
            n_err++;
            k = 0;
            for (int i = CH - 1; i >= 0; i--) begin
                if (od[i*DW +: DW] !== ed[i*DW +: DW] || of_[i] !== ef[i]) k = i;
            end
            $error("FAIL %s: ch%0d got %0d/%0b expected %0d/%0b", tag, k,
                   $signed(od[k*DW +: DW]), of_[k], $signed(ed[k*DW +: DW]), ef[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_in();
        data_in = '0;
        res     = '0;
        bn_a    = '0;
        bn_b    = '0;
        res_en  = 1'b0;
    endtask

    task automatic set_ch(int i, int a, int x, int b);
        bn_a[i*PW +: PW]    = PW'(a);
        data_in[i*IW +: IW] = IW'(x);
        bn_b[i*PW +: PW]    = PW'(b);
    endtask

    task automatic rand_beat();
        for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 3) == 0) bn_a[i*PW +: PW] = PW'($urandom);
            else bn_a[i*PW +: PW] = PW'($urandom_range(0, 255) - 128);
            data_in[i*IW +: IW] = IW'($urandom);
            bn_b[i*PW +: PW]    = PW'($urandom);
        end
        for (int i = 0; i < FM; i++) res[i*DW +: DW] = DW'($urandom);
        res_en = 1'($urandom_range(0, 1));
    endtask

    task automatic run_stream(int nbeats, bit stall_pat);
        logic [CH*DW-1:0] qd[$];
        logic [CH-1:0]    qf[$];
        logic [CH*DW-1:0] ed;
        logic [CH-1:0]    ef;
        int  sent, got, n, cyc, add;
        bit  just, acc, hs, pend;
        sent = 0; got = 0; n = 0; cyc = 0;
        just = 1'b0; pend = 1'b0;
        while (got < nbeats && cyc < 600) begin
            if (!pend && sent < nbeats) begin
                rand_beat();
                pend = 1'b1;
            end
            in_valid  = pend && (stall_pat || $urandom_range(0, 3) != 0);
            out_ready = stall_pat ? !(cyc >= 3 && cyc <= 6)
                                  : ($urandom_range(0, 2) != 0);
            sat_clr   = !stall_pat && ($urandom_range(0, 15) == 0);
            #1;
            chk_v("in_ready", in_ready, !(n == 2 && !out_ready));
            chk_v("out_valid", out_valid, n == 2 || (n == 1 && !just));
            if (out_valid && qd.size() > 0)
                chk("stream data", data_out, qd[0], sat_flag, qf[0]);
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (acc) begin
                expect_main(ed, ef);
                qd.push_back(ed);
                qf.push_back(ef);
            end
            tick();
            add = 0;
            if (hs && qf.size() > 0) begin
                add = $countones(qf[0]);
                void'(qd.pop_front());
                void'(qf.pop_front());
                got++;
                n--;
            end
            exp_cnt = sat_clr ? 0 : exp_cnt + add;
            if (exp_cnt > 64'hFFFF_FFFF) exp_cnt = 64'hFFFF_FFFF;
            if (acc) begin
                sent++;
                n++;
                pend = 1'b0;
            end
            just = acc;
            cyc++;
            chk_v("sat_cnt", sat_cnt, exp_sat());
        end
        chk_v("stream beats out", got, nbeats);
        in_valid  = 1'b0;
        sat_clr   = 1'b0;
        out_ready = 1'b1;
    endtask

    logic [CH*DW-1:0] ed;
    logic [CH-1:0]    ef;
    logic [CH-1:0]    two_flags;
    bit               f2;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sat_clr = 1'b0;
        zero_in();
        d2_in_valid = 1'b0;
        d2_data_in = '0;
        d2_res = '0;
        d2_bn_a = '0;
        d2_bn_b = '0;
        tick();
        tick();
        chk_v("rst in_ready", in_ready, 0);
        chk_v("rst out_valid", out_valid, 0);
        chk_v("rst data_out", data_out[63:0], 0);
        chk_v("rst sat_flag", sat_flag[63:0], 0);
        chk_v("rst sat_cnt", sat_cnt, 0);
        rst = 1'b0;
        #1;
        chk_v("post-rst in_ready", in_ready, 1);

        // Basic residual / non-residual channel
        zero_in();
        set_ch(0, 2, 5, 3);
        set_ch(100, 2, 5, 3);
        res[0 +: DW] = 16'd7;
        res_en = 1'b1;
        in_valid = 1'b1;
        expect_main(ed, ef);
        tick();
        in_valid = 1'b0;
        chk_v("basic lat1 out_valid", out_valid, 0);
        tick();
        chk_v("basic out_valid", out_valid, 1);
        chk_v("basic ch0", $signed(data_out[0 +: DW]), 20);
        chk_v("basic ch100", $signed(data_out[100*DW +: DW]), 13);
        chk("basic vec", data_out, ed, sat_flag, ef);
        tick();

        // Saturation at both bounds
        zero_in();
        set_ch(0, 32767, 127, 32767);
        set_ch(1, -32768, 127, 0);
        in_valid = 1'b1;
        expect_main(ed, ef);
        tick();
        in_valid = 1'b0;
        tick();
        two_flags = '0;
        two_flags[1:0] = 2'b11;
        chk_v("sat hi", $signed(data_out[0 +: DW]), 32767);
        chk_v("sat lo", $signed(data_out[DW +: DW]), -32768);
        chk("sat flags", data_out, ed, sat_flag, two_flags);
        tick();

        // Rounding with FRAC_SHIFT=2
        d2_bn_a = {16'sd1, 16'sd1, 16'sd1, 16'sd1};
        d2_data_in = {-8'sd5, 8'sd5, -8'sd6, 8'sd6};
        d2_in_valid = 1'b1;
        tick();
        d2_in_valid = 1'b0;
        tick();
        chk_v("rnd out_valid", d2_out_valid, 1);
        chk_v("rnd 6", $signed(d2_data_out[0 +: DW]), 2);
        chk_v("rnd -6", $signed(d2_data_out[DW +: DW]), -1);
        chk_v("rnd 5", $signed(d2_data_out[2*DW +: DW]), 1);
        chk_v("rnd -5", $signed(d2_data_out[3*DW +: DW]),
              ref_ch(1, -5, 0, 0, 2, f2));
        tick();

        // Back-pressure and random streams
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        exp_cnt = 0;
        run_stream(10, 1'b1);
        run_stream(60, 1'b0);

        // Reset with both stages full
        zero_in();
        rand_beat();
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        #1;
        chk_v("full in_ready", in_ready, 0);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        exp_cnt = 0;
        chk_v("mid-rst out_valid", out_valid, 0);
        chk("mid-rst data", data_out, '0, sat_flag, '0);
        chk_v("mid-rst sat_cnt", sat_cnt, 0);
        chk_v("mid-rst in_ready", in_ready, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk_v("after-rst in_ready", in_ready, 1);
        rand_beat();
        in_valid = 1'b1;
        expect_main(ed, ef);
        tick();
        in_valid = 1'b0;
        chk_v("after-rst lat1", out_valid, 0);
        tick();
        chk_v("after-rst lat2", out_valid, 1);
        chk("after-rst data", data_out, ed, sat_flag, ef);
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk_v("clr sat_cnt", sat_cnt, 0);

        // Counter: 3 beats x 4 saturated channels, clear on 4th handshake
        zero_in();
        for (int i = 0; i < 4; i++) set_ch(i, 32767, 127, 32767);
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        tick();
`ifdef BN_RES_SAT_CNT_EN
        chk_v("cnt 3 beats", sat_cnt, 12);
`else
        chk_v("cnt 3 beats", sat_cnt, 0);
`endif
        chk_v("cnt 4th valid", out_valid, 1);
        chk_v("cnt 4th flags", sat_flag[7:0], 8'h0F);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk_v("cnt clr wins", sat_cnt, 0);
        chk_v("cnt drained", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bn_res_pipe.md
# bn_res_pipe

Parametrised successor of the layer batch-norm/residual stage: per channel computes `bn_a*data_in + bn_b (+ residual)`, applies a rounding right shift and saturates to the activation width. It sits between the partial-sum block and RPReLU. It adds a two-stage registered pipeline with valid/ready back-pressure, a run-time residual enable and an optional saturation event counter.

## Interface
Parameters:
- IN_WIDTH, 8, signed width of `data_in` per channel
- PARA_WIDTH, 16, signed width of `bn_a`/`bn_b`
- DATA_WIDTH, 16, signed width of `res` and `data_out`
- CHANNEL_NUM, 128, channels processed per beat
- FM_DEPTH, 64, number of low channels (0..FM_DEPTH-1) that receive a residual; FM_DEPTH ≤ CHANNEL_NUM
- FRAC_SHIFT, 0, arithmetic right shift applied before saturation (0..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- res_en  in  1  add residual for this beat; sampled with the beat
- data_in  in  CHANNEL_NUM×IN_WIDTH  signed data from partial sum
- res  in  FM_DEPTH×DATA_WIDTH  signed residual
- bn_a, bn_b  in  CHANNEL_NUM×PARA_WIDTH  signed BN parameters; quasi-static
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- data_out  out  CHANNEL_NUM×DATA_WIDTH  signed result to RPReLU
- sat_flag  out  CHANNEL_NUM  per-channel saturation occurred on current output beat
- sat_cnt  out  32  saturation event count (macro-dependent)
- sat_clr  in  1  clear `sat_cnt` (macro-dependent)

## Operation
- Stage 1 (S1): on accept (`in_valid && in_ready`), register `prod[i] = bn_a[i]*data_in[i]` (full IN_WIDTH+PARA_WIDTH bits), `res[i]` gated by `res_en` (zero when low), and `bn_b[i]`; set v1.
- Stage 2 (S2): `sum = prod + bn_b + res_gated` in SUM_W = IN_WIDTH+PARA_WIDTH+2 bits, no intermediate truncation. Channels ≥ FM_DEPTH never add residual.
- Rounding: if FRAC_SHIFT>0 add `1<<(FRAC_SHIFT-1)` then arithmetic shift right (round half up); FRAC_SHIFT=0 passes through.
- Saturation: clamp to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]; `sat_flag[i]=1` when clamped. Result, flags registered into S2 output; set v2.
- Handshake: `en2 = !v2 || out_ready`; `en1 = !v1 || en2`; `in_ready = en1`. Bubbles collapse; `in_ready` depends combinationally on `out_ready`.
- S1 loads when en1 (v1 ← in_valid); S2 loads when en2 (v2 ← v1). Registers hold when not enabled.
- `out_valid = v2`; once asserted, `data_out`/`sat_flag` stay stable until `out_ready`.
- `bn_a`/`bn_b` are sampled in S1 only; may change between beats.

## Timing
- Latency: accepted beat at edge N appears on `out_valid` after edge N+1 (2 registers).
- Throughput: 1 beat/cycle with `out_ready` high.
- Full: v1 && v2 && !out_ready → `in_ready=0`.
- Reset (any cycle, including mid-stall): v1=v2=0, `out_valid=0`, `in_ready=1` after reset deasserts, `data_out=0`, `sat_flag=0`, `sat_cnt=0`; in-flight beats are discarded.
- `in_ready` is 0 while `rst` is high.

## Configuration
- `BN_RES_SAT_CNT_EN` defined: `sat_cnt` increments by popcount(`sat_flag`) on each output handshake (`out_valid && out_ready`), saturating at 2^32−1; `sat_clr` zeroes it synchronously and wins over a same-cycle increment.
- Undefined: `sat_cnt` tied to 0, `sat_clr` ignored, no counter logic; `sat_flag` still produced.

## Structure
- Package `bn_res_pkg`: SUM_W derivation function, `sat_round` function (sum, shift → clamped value + flag), saturation bound constants.
- Sub-module `bn_res_lane`: one channel's S1 multiply and S2 add/round/saturate datapath, enable inputs from the top; top holds valid bits, handshake, counter, generate loop.

## Test plan
- Basic: bn_a=2, data_in=5, bn_b=3, res=7, res_en=1, ch 0 → data_out=20 two cycles later; ch 100 (≥FM_DEPTH) same inputs → 13.
- Saturation: bn_a=32767, data_in=127, bn_b=32767 → 32767, sat_flag=1; bn_a=−32768, data_in=127 → −32768, sat_flag=1.
- Rounding: FRAC_SHIFT=2, sum=6 → 2; sum=−6 → −1; sum=5 → 1.
- Back-pressure: stream 10 beats, out_ready low for cycles 3–6 → in_ready drops after two beats buffered, all 10 emitted in order, none lost or duplicated, data stable during stall.
- Reset mid-stream: rst high with v1=v2=1 → next cycle out_valid=0, data_out=0, sat_cnt=0; first beat after reset emerges with latency 2.
- Counter (macro on): 3 beats each with 4 saturated channels → sat_cnt=12; sat_clr concurrent with 4th beat handshake → 0.
